clk_rst_sequencer: RTL

Reset sequencer in the system clock domain, sitting directly downstream of the MMCM/PLL clocking stage. It synchronises the asynchronous MMCM and PLL `locked` indications and waits for a stable-lock window. It then releases peripheral reset first and core reset last, and re-asserts both immediately on any loss of lock. It also offers a software-requested core-only reset and an optional lock-loss event counter.

---
 rtl/clk_rst_sequencer.sv | 103 ++++++++++
 1 files changed

// File: rtl/clk_rst_sequencer.sv
// Reset sequencer: synchronises MMCM/PLL lock, qualifies a stable window, then releases
// peripheral reset before core reset. Optional lock-loss counter: CLK_LOCK_LOSS_CNT_EN.
module clk_rst_sequencer #(
   parameter int SYNC_STAGES        = 2,
   parameter int LOCK_STABLE_CYCLES = 1024,
   parameter int RST_HOLD_CYCLES    = 16
) (
   input  logic       clk_i,
   input  logic       rst_ni,
   input  logic       mmcm_locked_i,
   input  logic       pll_locked_i,
   input  logic       sw_rst_req_i,
   output logic       periph_rst_no,
   output logic       core_rst_no,
   output logic       clock_ok_o,
   output logic [7:0] lock_loss_cnt_o
);

   localparam int CNT_MAX = (LOCK_STABLE_CYCLES > RST_HOLD_CYCLES) ? LOCK_STABLE_CYCLES
                                                                   : RST_HOLD_CYCLES;
   localparam int CW = (CNT_MAX < 2) ? 1 : $clog2(CNT_MAX);
   localparam logic [CW-1:0] STABLE_LAST = CW'(LOCK_STABLE_CYCLES - 1);
   localparam logic [CW-1:0] HOLD_LAST   = CW'(RST_HOLD_CYCLES - 1);

   typedef enum logic [2:0] {WAIT_LOCK, STABLE, PERIPH, RUN, SWRST} state_t;

   state_t                 state, state_nxt;
   logic [CW-1:0]          cnt;
   logic [SYNC_STAGES-1:0] mmcm_sync, pll_sync;
   logic                   locked_s;

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         mmcm_sync <= '0;
         pll_sync  <= '0;
      end else begin
         mmcm_sync <= {mmcm_sync[SYNC_STAGES-2:0], mmcm_locked_i};
         pll_sync  <= {pll_sync[SYNC_STAGES-2:0], pll_locked_i};
      end
   end

   assign locked_s = mmcm_sync[SYNC_STAGES-1] & pll_sync[SYNC_STAGES-1];

   // Lock loss is checked first in every state so it wins over sw requests and terminal counts.
   always_comb begin
      state_nxt = state;
      case (state)
         WAIT_LOCK: if (locked_s) state_nxt = STABLE;
         STABLE: begin
            if (!locked_s)              state_nxt = WAIT_LOCK;
            else if (cnt == STABLE_LAST) state_nxt = PERIPH;
         end
         PERIPH, SWRST: begin
            if (!locked_s)            state_nxt = WAIT_LOCK;
            else if (cnt == HOLD_LAST) state_nxt = RUN;
         end
         RUN: begin
            if (!locked_s)         state_nxt = WAIT_LOCK;
            else if (sw_rst_req_i) state_nxt = SWRST;
         end
         default: state_nxt = WAIT_LOCK;
      endcase
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state         <= WAIT_LOCK;
         cnt           <= '0;
         periph_rst_no <= 1'b0;
         core_rst_no   <= 1'b0;
         clock_ok_o    <= 1'b0;
      end else begin
         state <= state_nxt;
         if (state_nxt != state || state == WAIT_LOCK || state == RUN)
            cnt <= '0;
         else
            cnt <= cnt + 1'b1;
         periph_rst_no <= (state_nxt inside {PERIPH, RUN, SWRST});
         core_rst_no   <= (state_nxt == RUN);
         clock_ok_o    <= (state_nxt == RUN);
      end
   end

`ifdef CLK_LOCK_LOSS_CNT_EN
   // Only losses after release (RUN or SWRST) are counted.
   logic       lose;
   logic [7:0] loss_cnt;

   assign lose = !locked_s && (state == RUN || state == SWRST);

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni)
         loss_cnt <= 8'd0;
      else if (lose && loss_cnt != 8'hFF)
         loss_cnt <= loss_cnt + 8'd1;
   end

   assign lock_loss_cnt_o = loss_cnt;
`else
   assign lock_loss_cnt_o = 8'd0;
`endif

endmodule
